// File: rtl/lock_key_sequencer.sv
// -----------------------------------------------------------------------------
// lock_key_sequencer
//
// Purpose:
//   Loads a key into a key-locked FSM core and then runs it. The key arrives
//   as a serial stream of single-bit beats on a valid/ready handshake, LSB
//   first. Its length is checked against KEY_W. A well-formed key is
//   committed to the core in one step. The core is then held in reset for
//   RST_CYC cycles, after which the primary inputs are passed through to it.
//   A malformed key, or a stalled key stream, parks the sequencer in an error
//   state. From the error state a reload request starts a clean new load.
//
// Ports:
//   clk        in   1     clock, all state on posedge
//   rst        in   1     asynchronous reset, active-high
//   key_valid  in   1     key beat valid
//   key_bit    in   1     key beat data
//   key_last   in   1     marks the final key beat
//   key_ready  out  1     sequencer accepts a key beat (LOAD state)
//   reload     in   1     single-cycle request to start a new key load
//   x_in       in   IN_W  primary inputs from the environment
//   x_out      out  IN_W  gated inputs to the core (zero unless core_en)
//   core_key   out  KEY_W committed key to the core
//   core_rst   out  1     reset to the core, active-high
//   core_en    out  1     core running
//   load_done  out  1     key committed and core running
//   load_err   out  1     last load was malformed or timed out
// -----------------------------------------------------------------------------
module lock_key_sequencer #(
   parameter int KEY_W   = 1,
   parameter int IN_W    = 10,
   parameter int RST_CYC = 4,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic             key_bit,
   input  logic             key_last,
   output logic             key_ready,
   input  logic             reload,
   input  logic [IN_W-1:0]  x_in,
   output logic [IN_W-1:0]  x_out,
   output logic [KEY_W-1:0] core_key,
   output logic             core_rst,
   output logic             core_en,
   output logic             load_done,
   output logic             load_err
);

   // Counter widths are kept at least one bit wide so that the degenerate
   // parameter values (KEY_W=1, RST_CYC=1) still elaborate cleanly.
   localparam int CNT_W = (KEY_W   > 1) ? $clog2(KEY_W)   : 1;
   localparam int RCY_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W - 1);
   localparam logic [RCY_W-1:0] RCY_MAX  = RCY_W'(RST_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_LOAD     = 3'd1,
      S_CORE_RST = 3'd2,
      S_RUN      = 3'd3,
      S_ERR      = 3'd4
   } state_t;

   state_t             state_q,    state_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [TMO_W-1:0]   tmo_q,      tmo_d;
   logic [RCY_W-1:0]   rcy_q,      rcy_d;
   logic [KEY_W-1:0]   shadow_q,   shadow_d;
   logic [KEY_W-1:0]   core_key_q, core_key_d;

   logic               key_ready_q;
   logic               core_rst_q;
   logic               core_en_q;
   logic               load_done_q;
   logic               load_err_q;

   logic               beat;

   // A beat only counts while the registered ready is high; beats offered in
   // any other state are silently dropped.
   assign beat = key_valid && key_ready_q;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      rcy_d      = rcy_q;
      shadow_d   = shadow_q;
      core_key_d = core_key_q;

      case (state_q)
         S_INIT: begin
            state_d = S_LOAD;
            cnt_d   = '0;
            tmo_d   = '0;
         end

         S_LOAD: begin
            if (reload) begin
               // Restart: stale shadow bits are simply overwritten later.
               cnt_d = '0;
               tmo_d = '0;
            end else if (beat) begin
               for (int i = 0; i < KEY_W; i++) begin
                  if (cnt_q == CNT_W'(i)) begin
                     shadow_d[i] = key_bit;
                  end
               end
               tmo_d = '0;
               if (cnt_q == LAST_IDX) begin
                  if (key_last) begin
                     // Commit includes the bit arriving on this very beat.
                     core_key_d = shadow_d;
                     rcy_d      = '0;
                     state_d    = S_CORE_RST;
                  end else begin
                     state_d = S_ERR;        // key longer than KEY_W
                  end
               end else if (key_last) begin
                  state_d = S_ERR;           // key shorter than KEY_W
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (cnt_q != '0) begin
               // Idle timeout only runs once the first beat has landed.
               if (tmo_q == TMO_MAX) begin
                  state_d = S_ERR;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end

         S_CORE_RST: begin
            // reload is deliberately not looked at here.
            if (rcy_q == RCY_MAX) begin
               state_d = S_RUN;
            end else begin
               rcy_d = rcy_q + 1'b1;
            end
         end

         S_RUN: begin
            if (reload) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               tmo_d   = '0;
            end
         end

         S_ERR: begin
            if (reload) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               tmo_d   = '0;
            end
         end

         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State and registered outputs
   // --------------------------------------------------------------------------
   // Outputs are registered from the next state so that they line up with
   // the state register exactly and never see the key inputs combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         tmo_q       <= '0;
         rcy_q       <= '0;
         shadow_q    <= '0;
         core_key_q  <= '0;
         key_ready_q <= 1'b0;
         core_rst_q  <= 1'b1;
         core_en_q   <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         rcy_q       <= rcy_d;
         shadow_q    <= shadow_d;
         core_key_q  <= core_key_d;
         key_ready_q <= (state_d == S_LOAD);
         core_rst_q  <= (state_d != S_RUN);
         core_en_q   <= (state_d == S_RUN);
         load_done_q <= (state_d == S_RUN);
         load_err_q  <= (state_d == S_ERR);
      end
   end

   assign key_ready = key_ready_q;
   assign core_key  = core_key_q;
   assign core_rst  = core_rst_q;
   assign core_en   = core_en_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

   // Primary inputs reach the core only while it is running.
   assign x_out = core_en_q ? x_in : '0;

endmodule

// File: tb/tb_lock_key_sequencer.sv
module tb_lock_key_sequencer;

   logic clk;
   logic rst;

   // KEY_W=4 instance signals
   logic       kv4, kb4, kl4, rl4;
   logic [9:0] x4, xo4;
   logic [3:0] key4;
   logic       kr4, crst4, en4, done4, err4;

   // KEY_W=1 instance signals
   logic       kv1, kb1, kl1, rl1;
   logic [9:0] x1, xo1;
   logic [0:0] key1;
   logic       kr1, crst1, en1, done1, err1;

   int n_chk  = 0;
   int n_fail = 0;

   lock_key_sequencer #(.KEY_W(4), .IN_W(10), .RST_CYC(4), .TIMEOUT(8)) dut4 (
      .clk(clk), .rst(rst),
      .key_valid(kv4), .key_bit(kb4), .key_last(kl4), .key_ready(kr4),
      .reload(rl4), .x_in(x4), .x_out(xo4), .core_key(key4),
      .core_rst(crst4), .core_en(en4), .load_done(done4), .load_err(err4)
   );

   lock_key_sequencer #(.KEY_W(1), .IN_W(10), .RST_CYC(4), .TIMEOUT(8)) dut1 (
      .clk(clk), .rst(rst),
      .key_valid(kv1), .key_bit(kb1), .key_last(kl1), .key_ready(kr1),
      .reload(rl1), .x_in(x1), .x_out(xo1), .core_key(key1),
      .core_rst(crst1), .core_en(en1), .load_done(done1), .load_err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v, b, l, rl;
      logic [9:0] x;
      byte        st;     // expected state: "L" "C" "R" "E"
      logic [3:0] key;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic b, input logic l, input logic rl,
                      input logic [9:0] x, input byte st, input logic [3:0] key);
      vec_t e;
      e.v = v; e.b = b; e.l = l; e.rl = rl; e.x = x; e.st = st; e.key = key;
      tbl.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected outputs of the KEY_W=4 instance for a given state.
   task automatic chk4(input string tag, input byte st, input logic [3:0] key);
      chk({tag, " key_ready"}, 32'(kr4),   32'(st == "L"));
      chk({tag, " core_rst"},  32'(crst4), 32'(st != "R"));
      chk({tag, " core_en"},   32'(en4),   32'(st == "R"));
      chk({tag, " load_done"}, 32'(done4), 32'(st == "R"));
      chk({tag, " load_err"},  32'(err4),  32'(st == "E"));
      chk({tag, " core_key"},  32'(key4),  32'(key));
      chk({tag, " x_out"},     32'(xo4),   (st == "R") ? 32'(x4) : 32'd0);
   endtask

   task automatic step4(input logic v, input logic b, input logic l, input logic rl);
      @(negedge clk);
      kv4 = v; kb4 = b; kl4 = l; rl4 = rl;
      @(posedge clk);
      #1;
   endtask

   task automatic step1(input logic v, input logic b, input logic l, input logic rl);
      @(negedge clk);
      kv1 = v; kb1 = b; kl1 = l; rl1 = rl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      kv4 = 0; kb4 = 0; kl4 = 0; rl4 = 0; x4 = 10'h3FF;
      kv1 = 0; kb1 = 0; kl1 = 0; rl1 = 0; x1 = 10'h2A5;

      // Directed vectors for the KEY_W=4 instance (applied one per cycle)
      add(0,0,0,0, 10'h3FF, "L", 4'h0);   // INIT -> LOAD
      add(1,1,0,0, 10'h3FF, "L", 4'h0);
      add(1,0,1,0, 10'h3FF, "E", 4'h0);   // short key
      add(1,1,0,0, 10'h3FF, "E", 4'h0);   // beat dropped while not ready
      add(0,0,0,1, 10'h3FF, "L", 4'h0);   // reload clears error
      add(1,1,0,0, 10'h3FF, "L", 4'h0);
      add(1,0,0,0, 10'h3FF, "L", 4'h0);
      add(1,1,0,0, 10'h3FF, "L", 4'h0);
      add(1,1,1,0, 10'h3FF, "C", 4'hD);   // commit 4'b1101
      add(0,0,0,1, 10'h3FF, "C", 4'hD);   // reload ignored in CORE_RST
      add(0,0,0,0, 10'h3FF, "C", 4'hD);
      add(0,0,0,0, 10'h3FF, "C", 4'hD);
      add(0,0,0,0, 10'h2A5, "R", 4'hD);
      add(0,0,1,0, 10'h155, "R", 4'hD);   // key_last without valid
      add(0,0,0,1, 10'h155, "L", 4'hD);   // reload from RUN, key kept
      add(1,0,0,0, 10'h155, "L", 4'hD);
      add(1,1,0,0, 10'h155, "L", 4'hD);
      add(1,0,0,0, 10'h155, "L", 4'hD);
      add(1,0,1,0, 10'h155, "C", 4'h2);   // commit 4'b0010
      add(0,0,0,0, 10'h155, "C", 4'h2);
      add(0,0,0,0, 10'h155, "C", 4'h2);
      add(0,0,0,0, 10'h155, "C", 4'h2);
      add(0,0,0,0, 10'h155, "R", 4'h2);
      add(0,0,0,1, 10'h155, "L", 4'h2);
      add(1,1,0,0, 10'h155, "L", 4'h2);
      add(1,1,0,0, 10'h155, "L", 4'h2);
      add(1,1,0,0, 10'h155, "L", 4'h2);
      add(1,1,0,0, 10'h155, "E", 4'h2);   // long key
      add(0,0,0,1, 10'h155, "L", 4'h2);
      add(1,1,0,0, 10'h155, "L", 4'h2);
      add(1,1,0,0, 10'h155, "L", 4'h2);
      add(0,0,0,1, 10'h155, "L", 4'h2);   // restart mid-load
      add(1,0,0,0, 10'h155, "L", 4'h2);
      add(1,0,0,0, 10'h155, "L", 4'h2);
      add(1,1,0,0, 10'h155, "L", 4'h2);
      add(1,1,1,0, 10'h155, "C", 4'hC);   // commit 4'b1100
      add(0,0,0,0, 10'h155, "C", 4'hC);
      add(0,0,0,0, 10'h155, "C", 4'hC);
      add(0,0,0,0, 10'h155, "C", 4'hC);
      add(0,0,0,0, 10'h2A5, "R", 4'hC);

      // Reset values
      #2 rst = 1'b1;
      #1;
      chk4("reset", "I", 4'h0);
      chk("reset dut1 key_ready", 32'(kr1),   32'd0);
      chk("reset dut1 core_rst",  32'(crst1), 32'd1);
      chk("reset dut1 core_key",  32'(key1),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk4("init", "I", 4'h0);

      // Table-driven section
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         kv4 = tbl[i].v; kb4 = tbl[i].b; kl4 = tbl[i].l; rl4 = tbl[i].rl; x4 = tbl[i].x;
         @(posedge clk);
         #1;
         chk4($sformatf("vec%0d", i), tbl[i].st, tbl[i].key);
      end

      // No timeout before the first beat, then timeout after 8 idle cycles
      step4(0,0,0,1);
      repeat (100) step4(0,0,0,0);
      chk4("idle100", "L", 4'hC);
      step4(1,1,0,0);
      repeat (7) step4(0,0,0,0);
      chk4("idle7", "L", 4'hC);
      step4(0,0,0,0);
      chk4("timeout", "E", 4'hC);

      // Asynchronous reset in the middle of a load
      step4(0,0,0,1);
      step4(1,1,0,0);
      chk4("preRst", "L", 4'hC);
      @(negedge clk);
      kv4 = 0; kb4 = 0; kl4 = 0; rl4 = 0;
      #2 rst = 1'b1;
      #1;
      chk4("midRst", "I", 4'h0);
      @(posedge clk);
      #1;
      chk4("midRstHold", "I", 4'h0);
      @(negedge clk);
      rst = 1'b0;

      // KEY_W=1 instance: single-beat key and core reset pulse length
      step1(0,0,0,0);
      chk("k1 load key_ready", 32'(kr1), 32'd1);
      chk("k1 load x_out",     32'(xo1), 32'd0);
      step1(1,1,1,0);
      chk("k1 commit core_key", 32'(key1),  32'd1);
      chk("k1 commit core_rst", 32'(crst1), 32'd1);
      chk("k1 commit core_en",  32'(en1),   32'd0);
      for (int c = 0; c < 3; c++) begin
         step1(0,0,0,0);
         chk($sformatf("k1 rst%0d core_rst", c), 32'(crst1), 32'd1);
         chk($sformatf("k1 rst%0d core_en", c),  32'(en1),   32'd0);
      end
      step1(0,0,0,0);
      chk("k1 run core_rst",  32'(crst1), 32'd0);
      chk("k1 run core_en",   32'(en1),   32'd1);
      chk("k1 run load_done", 32'(done1), 32'd1);
      chk("k1 run x_out",     32'(xo1),   32'h2A5);
      chk("k1 run core_key",  32'(key1),  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
